signmag_addsub: RTL and testbench



---
 rtl/signmag_addsub.sv | 112 +++++++++++
 tb/tb_signmag_addsub.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/signmag_addsub.sv
// Sign-magnitude adder/subtractor with a start/finish handshake.
// Operands are captured on the start edge; the result is registered.
module signmag_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  input  logic             sat_en,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             busy,
  output logic             finish
);

  localparam int M = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADD, S_DONE} state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_a, r_b;
  logic             r_sub, r_sat;
  logic [M-1:0]     r_big, r_small;
  logic             r_same, r_sa, r_sign_big;

  logic [M-1:0]     w_ma, w_mb;
  logic             w_sa, w_sb, w_a_ge;
  logic [M-1:0]     w_sum, w_diff, w_mag;
  logic             w_cout, w_ovf, w_sign;
  logic [WIDTH-1:0] w_res;

  // A zero magnitude always carries a positive sign, so -0 behaves as +0.
  assign w_ma   = r_a[M-1:0];
  assign w_mb   = r_b[M-1:0];
  assign w_sa   = r_a[M] & (|w_ma);
  assign w_sb   = (r_b[M] ^ r_sub) & (|w_mb);
  assign w_a_ge = (w_ma >= w_mb);

  always_comb begin
    logic c;
    c = 1'b0;
    for (int unsigned i = 0; i < M; i++) begin
      w_sum[i] = r_big[i] ^ r_small[i] ^ c;
      c        = (r_big[i] & r_small[i]) | (c & (r_big[i] ^ r_small[i]));
    end
    w_cout = c;
  end

  assign w_diff = r_big - r_small;
  assign w_ovf  = r_same & w_cout;
  assign w_mag  = r_same ? ((w_ovf & r_sat) ? '1 : w_sum) : w_diff;
  assign w_sign = r_same ? r_sa : r_sign_big;
  assign w_res  = (w_mag == '0) ? '0 : {w_sign, w_mag};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = S_ADD;
      S_ADD:   w_next = S_DONE;
      S_DONE:  if (!start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sub      <= 1'b0;
      r_sat      <= 1'b0;
      r_big      <= '0;
      r_small    <= '0;
      r_same     <= 1'b0;
      r_sa       <= 1'b0;
      r_sign_big <= 1'b0;
      out        <= '0;
      overflow   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_a   <= in1;
          r_b   <= in2;
          r_sub <= sub;
          r_sat <= sat_en;
        end
        S_LOAD: begin
          r_same     <= (w_sa == w_sb);
          r_sa       <= w_sa;
          r_big      <= w_a_ge ? w_ma : w_mb;
          r_small    <= w_a_ge ? w_mb : w_ma;
          r_sign_big <= w_a_ge ? w_sa : w_sb;
        end
        S_ADD: begin
          out      <= w_res;
          overflow <= w_ovf;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign finish = (r_state == S_DONE);

endmodule

// File: tb/tb_signmag_addsub.sv
// Self-checking bench: 16-bit and 8-bit instances run in lockstep against
// a signed-integer reference model.
module tb_signmag_addsub;

  logic        clk = 1'b0;
  logic        nRST;
  logic [15:0] in1, in2, out;
  logic [7:0]  in1_8, in2_8, out_8;
  logic        sub, sat_en, start;
  logic        overflow, busy, finish;
  logic        overflow_8, busy_8, finish_8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  signmag_addsub #(.WIDTH(16)) u_dut16 (
    .clk(clk), .nRST(nRST), .in1(in1), .in2(in2), .sub(sub), .sat_en(sat_en),
    .start(start), .out(out), .overflow(overflow), .busy(busy), .finish(finish)
  );

  signmag_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .nRST(nRST), .in1(in1_8), .in2(in2_8), .sub(sub), .sat_en(sat_en),
    .start(start), .out(out_8), .overflow(overflow_8), .busy(busy_8), .finish(finish_8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: interpret as signed integers, add, then map back to
  // sign-magnitude with wrap or saturation on magnitude overflow.
  function automatic logic [32:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic s,
                                        input logic sat);
    longint maxm, ma, mb, va, vb, r, mag, res;
    logic   neg, ovf;
    maxm = (longint'(1) << (w - 1)) - 1;
    ma   = longint'(a) & maxm;
    mb   = longint'(b) & maxm;
    va   = a[w-1] ? -ma : ma;
    vb   = b[w-1] ? -mb : mb;
    if (s) vb = -vb;
    r    = va + vb;
    neg  = (r < 0);
    mag  = neg ? -r : r;
    ovf  = (mag > maxm);
    if (ovf) mag = sat ? maxm : (mag % (maxm + 1));
    res  = (mag == 0) ? 0 : ((neg ? (longint'(1) << (w - 1)) : 0) | mag);
    return {ovf, res[31:0]};
  endfunction

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic [7:0] a8, input logic [7:0] b8,
                    input logic s, input logic sat, input int hold);
    logic [32:0] e16, e8;
    int n;
    e16 = model(16, 32'(a), 32'(b), s, sat);
    e8  = model(8, 32'(a8), 32'(b8), s, sat);
    @(negedge clk);
    in1 = a; in2 = b; in1_8 = a8; in2_8 = b8; sub = s; sat_en = sat; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Operands after the capture edge must be ignored.
    in1 = 16'($urandom); in2 = 16'($urandom);
    in1_8 = 8'($urandom); in2_8 = 8'($urandom);
    sub = 1'($urandom); sat_en = 1'($urandom);
    check({tag, " busy_load"}, 32'(busy), 32'd1);
    n = 1;
    while (!finish && n < 8) begin
      @(negedge clk);
      n++;
    end
    // DONE is the third state after the capturing edge.
    check({tag, " latency"}, 32'(n), 32'd3);
    check({tag, " out16"}, 32'(out), e16[31:0]);
    check({tag, " ovf16"}, 32'(overflow), 32'(e16[32]));
    check({tag, " out8"}, 32'(out_8), e8[31:0]);
    check({tag, " ovf8"}, 32'(overflow_8), 32'(e8[32]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold_finish"}, 32'(finish), 32'd1);
      check({tag, " hold_out"}, 32'(out), e16[31:0]);
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " idle_finish"}, 32'(finish), 32'd0);
    check({tag, " idle_out"}, 32'(out), e16[31:0]);
  endtask

  initial begin
    nRST = 1'b0; start = 1'b0; sub = 1'b0; sat_en = 1'b0;
    in1 = '0; in2 = '0; in1_8 = '0; in2_8 = '0;
    #12;
    check("rst out", 32'(out), 32'd0);
    check("rst ovf", 32'(overflow), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst finish", 32'(finish), 32'd0);
    check("rst out8", 32'(out_8), 32'd0);
    @(negedge clk);
    nRST = 1'b1;

    op("add",     16'h0064, 16'h0019, 8'h64, 8'h19, 1'b0, 1'b0, 0);
    op("subneg",  16'h0019, 16'h0064, 8'h19, 8'h64, 1'b1, 1'b0, 0);
    op("negzero", 16'h8005, 16'h0005, 8'h85, 8'h05, 1'b0, 1'b0, 0);
    op("mzin",    16'h8000, 16'h8000, 8'h80, 8'h00, 1'b1, 1'b0, 0);
    op("satpos",  16'h7FFF, 16'h0001, 8'h7F, 8'h01, 1'b0, 1'b1, 0);
    op("wrapzero",16'h7FFF, 16'h0001, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
    op("wrapneg", 16'hC000, 16'h4001, 8'hC0, 8'h41, 1'b1, 1'b0, 0);
    op("satneg",  16'hC000, 16'h4001, 8'hC0, 8'h41, 1'b1, 1'b1, 0);
    op("hold",    16'h1234, 16'h8034, 8'h12, 8'h93, 1'b0, 1'b0, 10);

    // Asynchronous reset during ADD, after a nonzero result is on out.
    @(negedge clk);
    in1 = 16'h0010; in2 = 16'h0001; in1_8 = 8'h10; in2_8 = 8'h01; start = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    nRST = 1'b0;
    #1;
    check("arst out", 32'(out), 32'd0);
    check("arst finish", 32'(finish), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    start = 1'b0;
    #2 nRST = 1'b1;
    op("postrst", 16'h0064, 16'h0019, 8'h64, 8'h19, 1'b0, 1'b0, 0);

    for (int k = 0; k < 40; k++)
      op("rand", 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
         1'($urandom), 1'($urandom), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
